// File: rtl/vga_rx_decoder.sv
// TinyVGA Pmod receiver: sync recovery, 640x480 lock,
// coordinate/pixel regeneration and per-frame lit-pixel count.
module vga_rx_decoder #(
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic        pix_out,
  output logic        locked,
  output logic        line_err,
  output logic        frame_done,
  output logic [18:0] frame_pix_count
);

  localparam logic [10:0] H_ST   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_EN   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_PRE  = 11'h7fe;
  localparam logic [9:0]  V_ST   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_EN   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  V_LNS  = 10'(V_TOTAL);
  localparam int          GW     = $clog2(LOCK_LINES + 1);
  localparam logic [GW-1:0] G_MAX = GW'(LOCK_LINES);

  typedef enum logic [1:0] {
    HUNT,
    H_LOCK,
    LOCKED
  } state_t;

  state_t state, st_nx;

  // bit 2 = hsync, bit 1 = vsync, bit 0 = pixel
  logic [2:0]    s1, s2, s3;
  logic [10:0]   hcnt, hcnt_nx;
  logic [9:0]    vcnt, vcnt_nx;
  logic [9:0]    lcnt, lcnt_nx;
  logic [GW-1:0] gcnt, gcnt_nx;
  logic [18:0]   pcnt, pcnt_nx;
  logic          vs_pend;
  logic          fvalid, fvalid_nx;
  logic          hs_fall, vs_fall;
  logic          sat_hit, good_line, bad_line;
  logic          frame_ok, act, lit, de_nx, lerr_nx;
  logic          unused_bits;

  assign unused_bits = ^{vga_in[6:4], vga_in[2:1]};
  assign locked = (state == LOCKED);

  always_comb begin
    hs_fall = s3[2] & ~s2[2];
    vs_fall = s3[1] & ~s2[1];

    hcnt_nx = hcnt;
    if (hs_fall)
      hcnt_nx = '0;
    else if (hcnt != '1)
      hcnt_nx = hcnt + 11'd1;

    // only the step into saturation counts, so a stuck line errs once
    sat_hit   = !hs_fall && (hcnt == H_PRE);
    good_line = hs_fall && (hcnt == H_LAST);
    bad_line  = (hs_fall && (hcnt != H_LAST)) || sat_hit;

    vcnt_nx = vcnt;
    lcnt_nx = lcnt;
    if (hs_fall) begin
      if (vs_pend)
        vcnt_nx = '0;
      else if (vcnt != '1)
        vcnt_nx = vcnt + 10'd1;
      if (lcnt != '1)
        lcnt_nx = lcnt + 10'd1;
    end
    frame_ok = fvalid && (lcnt_nx == V_LNS);

    act = (hcnt >= H_ST) && (hcnt < H_EN)
       && (vcnt >= V_ST) && (vcnt < V_EN);
    lit = act && s3[0];
    de_nx = act && (state == LOCKED);

    pcnt_nx = pcnt;
    if (lit && (pcnt != '1))
      pcnt_nx = pcnt + 19'd1;

    st_nx     = state;
    gcnt_nx   = gcnt;
    fvalid_nx = fvalid;
    lerr_nx   = 1'b0;

    unique case (1'b1)
      bad_line: begin
        gcnt_nx   = '0;
        fvalid_nx = 1'b0;
        if (state != HUNT) begin
          lerr_nx = 1'b1;
          st_nx   = HUNT;
        end
      end
      good_line: begin
        if (gcnt != G_MAX)
          gcnt_nx = gcnt + 1'b1;
        if ((state == HUNT) && (gcnt_nx >= G_MAX))
          st_nx = H_LOCK;
      end
      default: ;
    endcase

    // vsync acts on the state left by a coincident hsync edge
    if (vs_fall) begin
      fvalid_nx = 1'b1;
      if ((st_nx == H_LOCK) && frame_ok) begin
        st_nx = LOCKED;
      end else if ((st_nx == LOCKED) && !frame_ok) begin
        st_nx   = HUNT;
        gcnt_nx = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1              <= '0;
      s2              <= '0;
      s3              <= '0;
      hcnt            <= '0;
      vcnt            <= '0;
      lcnt            <= '0;
      gcnt            <= '0;
      pcnt            <= '0;
      vs_pend         <= 1'b0;
      fvalid          <= 1'b0;
      state           <= HUNT;
      x               <= '0;
      y               <= '0;
      de              <= 1'b0;
      pix_out         <= 1'b0;
      line_err        <= 1'b0;
      frame_done      <= 1'b0;
      frame_pix_count <= '0;
    end else begin
      s1      <= {vga_in[7], vga_in[3], vga_in[0]};
      s2      <= s1;
      s3      <= s2;
      hcnt    <= hcnt_nx;
      vcnt    <= vcnt_nx;
      lcnt    <= vs_fall ? '0 : lcnt_nx;
      gcnt    <= gcnt_nx;
      fvalid  <= fvalid_nx;
      state   <= st_nx;
      vs_pend <= vs_fall | (vs_pend & ~hs_fall);

      pcnt       <= vs_fall ? '0 : pcnt_nx;
      frame_done <= vs_fall;
      if (vs_fall)
        frame_pix_count <= pcnt_nx;

      line_err <= lerr_nx;
      de       <= de_nx;
      pix_out  <= de_nx & s3[0];
      if (de_nx) begin
        x <= 10'(hcnt - H_ST);
        y <= 10'(vcnt - V_ST);
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder on a shrunken
// 64x32 raster so several frames fit in a short run.
module tb_vga_rx_decoder;

  localparam int HS = 8;
  localparam int HB = 8;
  localparam int HA = 32;
  localparam int HT = 64;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 24;
  localparam int VT = 32;
  localparam int LL = 4;
  localparam int HO = HS + HB;
  localparam int VO = VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = 8'h88;
  logic [9:0]  x, y;
  logic        de, pix_out, locked, line_err, frame_done;
  logic [18:0] frame_pix_count;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int tgt = -100;
  int lerr_cnt = 0;
  int fd_cnt = 0;
  int pix_seen = 0;
  int e0, f0;
  logic [18:0] last_fpc = '0;

  vga_rx_decoder #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_LINES(LL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vga_in(vga_in),
    .x(x),
    .y(y),
    .de(de),
    .pix_out(pix_out),
    .locked(locked),
    .line_err(line_err),
    .frame_done(frame_done),
    .frame_pix_count(frame_pix_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (line_err) lerr_cnt++;
      if (frame_done) begin
        fd_cnt++;
        last_fpc = frame_pix_count;
      end
      if (pix_out) pix_seen++;
      if (cyc == tgt + 3)
        chk("pix_early", 32'(pix_out), 0);
      if (cyc == tgt + 4) begin
        chk("de_px", 32'(de), 1);
        chk("x_px", 32'(x), 10);
        chk("y_px", 32'(y), 20);
        chk("pix_px", 32'(pix_out), 1);
      end
    end
  end

  // mode 0 blank, 1 single pixel (10,20), 2 8x8 square
  // plus lit samples just outside the active columns
  task automatic send_line(input int l, input int nl,
                           input int len, input int mode);
    logic hs, vs, px;
    for (int p = 0; p < len; p++) begin
      hs = (p >= HS);
      vs = !((l == nl - 1 && p >= HO) || (l < VS - 1)
             || (l == VS - 1 && p < HO));
      px = 1'b0;
      if (mode == 1)
        px = (l == VO + 20) && (p == HO + 10);
      if (mode == 2)
        px = (l >= VO + 4) && (l < VO + 12)
          && ((p >= HO + 4 && p < HO + 12)
              || p == HO - 1 || p == HO + HA);
      @(negedge clk);
      vga_in = {hs, 3'b010, vs, 2'b10, px};
      if (mode == 1 && px) tgt = cyc;
    end
  endtask

  task automatic send_frame(input int first, input int nl,
                            input int mode, input int short_l);
    for (int l = first; l < nl; l++)
      send_line(l, nl, (l == short_l) ? HT - 1 : HT, mode);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vga_in = 8'h88;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_de", 32'(de), 0);
    chk("rst_pix", 32'(pix_out), 0);
    chk("rst_lock", 32'(locked), 0);
    chk("rst_lerr", 32'(line_err), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_fpc", 32'(frame_pix_count), 0);
    rst_n = 1'b1;

    idle(2000);
    chk("idle_lock", 32'(locked), 0);
    chk("idle_lerr", lerr_cnt, 0);
    chk("idle_fd", fd_cnt, 0);

    send_frame(2, VT, 0, -1);
    chk("lock_vs1", 32'(locked), 0);
    chk("fd_vs1", fd_cnt, 1);
    send_frame(0, VT, 0, -1);
    chk("lock_vs2", 32'(locked), 1);
    send_frame(0, VT, 0, -1);
    chk("lock_f2", 32'(locked), 1);
    send_frame(0, VT, 0, -1);
    chk("lock_f3", 32'(locked), 1);
    chk("lerr_none", lerr_cnt, 0);

    pix_seen = 0;
    send_frame(0, VT, 1, -1);
    chk("pix_once", pix_seen, 1);
    chk("fpc_one", 32'(last_fpc), 1);

    f0 = fd_cnt;
    send_frame(0, VT, 2, -1);
    chk("fpc_sq1", 32'(last_fpc), 64);
    send_frame(0, VT, 2, -1);
    chk("fpc_sq2", 32'(last_fpc), 64);
    chk("fd_per_frame", fd_cnt - f0, 2);
    send_frame(0, VT, 0, -1);
    chk("fpc_blank", 32'(last_fpc), 0);

    e0 = lerr_cnt;
    send_frame(0, VT, 0, 10);
    chk("short_lerr", lerr_cnt - e0, 1);
    chk("short_lock", 32'(locked), 0);
    send_frame(0, VT, 0, -1);
    chk("short_relock", 32'(locked), 1);

    e0 = lerr_cnt;
    send_frame(0, VT + 1, 0, -1);
    chk("long_fr_lock", 32'(locked), 0);
    chk("long_fr_lerr", lerr_cnt - e0, 0);
    send_frame(0, VT, 0, -1);
    chk("long_relock", 32'(locked), 1);

    e0 = lerr_cnt;
    idle(5000);
    chk("stuck_lerr", lerr_cnt - e0, 1);
    chk("stuck_lock", 32'(locked), 0);

    send_frame(0, VT, 2, -1);
    send_frame(0, VT, 2, -1);
    chk("pre_lock", 32'(locked), 1);
    for (int l = 0; l < 12; l++)
      send_line(l, VT, HT, 2);
    send_line(12, VT, 30, 2);
    #1;
    chk("pre_de", 32'(de), 1);
    chk("pre_fpc", 32'(frame_pix_count), 64);
    rst_n = 1'b0;
    #1;
    chk("arst_lock", 32'(locked), 0);
    chk("arst_de", 32'(de), 0);
    chk("arst_x", 32'(x), 0);
    chk("arst_y", 32'(y), 0);
    chk("arst_fpc", 32'(frame_pix_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_frame(13, VT, 0, -1);
    chk("post_rst_lock0", 32'(locked), 0);
    send_frame(0, VT, 0, -1);
    chk("post_rst_lock1", 32'(locked), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
